// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game engine and its paddle controller.
package pong_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  // Bit positions inside the evt pulse vector
  localparam int EVT_WALL  = 0;
  localparam int EVT_HIT_L = 1;
  localparam int EVT_HIT_R = 2;
  localparam int EVT_POINT = 3;

endpackage

// File: rtl/pong_engine_paddle.sv
// Clamped up/down paddle position register; moves one step per enabled tick.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SPEED  = 6,
  parameter int HEIGHT = 150,
  parameter int V_RES  = 480
) (
  input  logic               pixel_clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               up,
  input  logic               dn,
  output logic [COORD_W-1:0] y
);

  localparam logic signed [11:0] Y_MAX  = 12'(V_RES - HEIGHT);
  localparam logic signed [11:0] STEP   = 12'(SPEED);
  localparam logic [COORD_W-1:0] Y_INIT = COORD_W'((V_RES - HEIGHT) / 2);

  logic [COORD_W-1:0] y_q, y_d;
  logic signed [11:0] y_s, y_n;

  always_comb begin
    y_d = y_q;
    y_s = signed'({2'b00, y_q});
    y_n = y_s;
    // Both requests together cancel out
    if (en && (up != dn)) begin
      y_n = up ? (y_s - STEP) : (y_s + STEP);
      if (y_n < 12'sd0)      y_n = 12'sd0;
      else if (y_n > Y_MAX)  y_n = Y_MAX;
      y_d = y_n[COORD_W-1:0];
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) y_q <= Y_INIT;
    else          y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game logic: ball physics, paddle reflection, scoring and serve/play/over FSM.
// Optional macro PONG_SPEEDUP_EN: paddle hits speed the ball up to BALL_SPEED_MAX.
module pong_engine
  import pong_pkg::*;
#(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int BALL_SIZE      = 25,
  parameter int PADDLE_W       = 10,
  parameter int PADDLE_H       = 150,
  parameter int PADDLE_L_X     = 40,
  parameter int PADDLE_R_X     = 600,
  parameter int BALL_SPEED     = 4,
  parameter int BALL_SPEED_MAX = 10,
  parameter int PADDLE_SPEED   = 6,
  parameter int SCORE_MAX      = 9,
  parameter int SERVE_DELAY    = 60
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 pad_l_up,
  input  logic                 pad_l_dn,
  input  logic                 pad_r_up,
  input  logic                 pad_r_dn,
  output logic [COORD_W-1:0]   ball_x,
  output logic [COORD_W-1:0]   ball_y,
  output logic [COORD_W-1:0]   pad_l_y,
  output logic [COORD_W-1:0]   pad_r_y,
  output logic [3:0]           score_l,
  output logic [3:0]           score_r,
  output logic [2:0]           game_state,
  output logic                 game_over,
  output logic [3:0]           evt
);

  localparam logic [COORD_W-1:0] BX0 = COORD_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BY0 = COORD_W'((V_RES - BALL_SIZE) / 2);
  localparam logic signed [11:0] S_BY_MAX = 12'(V_RES - BALL_SIZE);
  localparam logic signed [11:0] S_BX_MAX = 12'(H_RES - BALL_SIZE);
  localparam logic signed [11:0] S_L_FACE = 12'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [11:0] S_R_FACE = 12'(PADDLE_R_X - BALL_SIZE);
  localparam logic signed [11:0] S_BSZ    = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_PH     = 12'(PADDLE_H);
  localparam logic [3:0]         SMAX     = 4'(SCORE_MAX);
  localparam logic [15:0]        DLY_LAST = 16'(SERVE_DELAY - 1);
  // Serve speed never exceeds the ceiling, even if misconfigured
  localparam logic [COORD_W-1:0] SPD0     =
    COORD_W'((BALL_SPEED > BALL_SPEED_MAX) ? BALL_SPEED_MAX : BALL_SPEED);

  game_state_t        state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic               dx_q, dx_d, dy_q, dy_d, sdy_q, sdy_d;
  logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
  logic [3:0]         evt_q, evt_d;
  logic               start_q;
  logic [COORD_W-1:0] spd;

`ifdef PONG_SPEEDUP_EN
  localparam logic [COORD_W-1:0] SPD_MAX = COORD_W'(BALL_SPEED_MAX);
  logic [COORD_W-1:0] spd_q, spd_d;
  assign spd = spd_q;
`else
  assign spd = SPD0;
`endif

  logic               start_edge, enter_serve, pad_en;
  logic               hit_l, hit_r, miss_l, miss_r;
  logic signed [11:0] bx_s, by_s, pl_s, pr_s, spd_s, nx, ny;

  assign pad_en = tick && ((state_q == SERVE) || (state_q == PLAY));

  paddle_ctrl #(.SPEED(PADDLE_SPEED), .HEIGHT(PADDLE_H), .V_RES(V_RES)) u_pad_l (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .en(pad_en),
    .up(pad_l_up), .dn(pad_l_dn), .y(pad_l_y)
  );

  paddle_ctrl #(.SPEED(PADDLE_SPEED), .HEIGHT(PADDLE_H), .V_RES(V_RES)) u_pad_r (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .en(pad_en),
    .up(pad_r_up), .dn(pad_r_dn), .y(pad_r_y)
  );

  always_comb begin
    bx_s  = signed'({2'b00, bx_q});
    by_s  = signed'({2'b00, by_q});
    pl_s  = signed'({2'b00, pad_l_y});
    pr_s  = signed'({2'b00, pad_r_y});
    spd_s = signed'({2'b00, spd});
    nx    = dx_q ? (bx_s + spd_s) : (bx_s - spd_s);
    ny    = dy_q ? (by_s + spd_s) : (by_s - spd_s);
    // Overlap uses the pre-update ball y against the current paddle y
    hit_l  = !dx_q && (bx_s >= S_L_FACE) && (nx <= S_L_FACE) &&
             (by_s + S_BSZ > pl_s) && (by_s < pl_s + S_PH);
    hit_r  = dx_q && (bx_s <= S_R_FACE) && (nx >= S_R_FACE) &&
             (by_s + S_BSZ > pr_s) && (by_s < pr_s + S_PH);
    miss_l = !dx_q && (nx <= 12'sd0) && !hit_l;
    miss_r = dx_q && (nx >= S_BX_MAX) && !hit_r;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sdy_d       = sdy_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    evt_d       = '0;
    enter_serve = 1'b0;
    start_edge  = start && !start_q;
`ifdef PONG_SPEEDUP_EN
    spd_d       = spd_q;
`endif

    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          enter_serve = 1'b1;
          score_l_d   = '0;
          score_r_d   = '0;
          dx_d        = 1'b1;
          dy_d        = 1'b1;
          sdy_d       = 1'b1;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt_q == DLY_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (!dy_q && (ny < 12'sd0)) begin
            by_d            = '0;
            dy_d            = 1'b1;
            evt_d[EVT_WALL] = 1'b1;
          end else if (dy_q && (ny > S_BY_MAX)) begin
            by_d            = S_BY_MAX[COORD_W-1:0];
            dy_d            = 1'b0;
            evt_d[EVT_WALL] = 1'b1;
          end else begin
            by_d = ny[COORD_W-1:0];
          end

          if (hit_l || hit_r) begin
            bx_d  = hit_l ? S_L_FACE[COORD_W-1:0] : S_R_FACE[COORD_W-1:0];
            dx_d  = hit_l;
            evt_d[EVT_HIT_L] = hit_l;
            evt_d[EVT_HIT_R] = hit_r;
`ifdef PONG_SPEEDUP_EN
            if (spd_q < SPD_MAX) spd_d = spd_q + 1'b1;
`endif
          end else if (miss_l || miss_r) begin
            // Ball holds x for the point tick; dx already aims at the conceder
            if (miss_l && (score_r_q < SMAX)) score_r_d = score_r_q + 4'd1;
            if (miss_r && (score_l_q < SMAX)) score_l_d = score_l_q + 4'd1;
            dx_d             = miss_r;
            evt_d[EVT_POINT] = 1'b1;
            state_d          = POINT;
          end else begin
            bx_d = nx[COORD_W-1:0];
          end
        end
      end
      POINT: begin
        if (tick) begin
          if ((score_l_q == SMAX) || (score_r_q == SMAX)) begin
            state_d = OVER;
          end else begin
            enter_serve = 1'b1;
            sdy_d       = !sdy_q;
            dy_d        = !sdy_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_serve) begin
      state_d = SERVE;
      cnt_d   = '0;
      bx_d    = BX0;
      by_d    = BY0;
`ifdef PONG_SPEEDUP_EN
      spd_d   = SPD0;
`endif
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bx_q      <= BX0;
      by_q      <= BY0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      sdy_q     <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      evt_q     <= '0;
      start_q   <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      spd_q     <= SPD0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      sdy_q     <= sdy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      evt_q     <= evt_d;
      start_q   <= start;
`ifdef PONG_SPEEDUP_EN
      spd_q     <= spd_d;
`endif
    end
  end

  assign ball_x     = bx_q;
  assign ball_y     = by_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_state = state_q;
  assign game_over  = (state_q == OVER);
  assign evt        = evt_q;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: serve timing, wall bounce, paddle clamp/hit, scoring, game over, reset.
module tb_pong_engine;

  logic       gclk = 1'b0;
  logic       grst_n;
  logic       tick, start;
  logic       pad_l_up, pad_l_dn, pad_r_up, pad_r_dn;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r, evt;
  logic [2:0] game_state;
  logic       game_over;

  int n_cmp = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  pong_engine dut (
    .pixel_clk(gclk), .reset_n(grst_n), .tick(tick), .start(start),
    .pad_l_up(pad_l_up), .pad_l_dn(pad_l_dn), .pad_r_up(pad_r_up), .pad_r_dn(pad_r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state),
    .game_over(game_over), .evt(evt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One tick strobe; returns on the negedge after the capturing posedge
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge gclk) tick = 1'b1;
      @(negedge gclk) tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge gclk) start = 1'b1;
    @(negedge gclk) start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, game_state, 0);
    chk({tag, "_bx"},    ball_x, 307);
    chk({tag, "_by"},    ball_y, 227);
    chk({tag, "_pl"},    pad_l_y, 165);
    chk({tag, "_pr"},    pad_r_y, 165);
    chk({tag, "_sl"},    score_l, 0);
    chk({tag, "_sr"},    score_r, 0);
    chk({tag, "_evt"},   evt, 0);
    chk({tag, "_over"},  game_over, 0);
  endtask

  initial begin
    grst_n = 1'b0; tick = 1'b0; start = 1'b0;
    pad_l_up = 1'b0; pad_l_dn = 1'b0; pad_r_up = 1'b0; pad_r_dn = 1'b0;
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;
    @(negedge gclk);
    chk_reset_vals("rst");

    // Paddles frozen in IDLE
    pad_l_up = 1'b1;
    tick_n(1);
    chk("idle_pad_frozen", pad_l_y, 165);

    // Game 1: serve timing, clamps, wall bounce, right paddle hit
    pulse_start();
    chk("start_serve", game_state, 1);
    pad_r_dn = 1'b1;
    tick_n(59);
    chk("serve_59", game_state, 1);
    tick_n(1);
    chk("serve_60_play", game_state, 2);
    chk("play0_bx", ball_x, 307);
    chk("pl_clamp0", pad_l_y, 0);
    chk("pr_clamp330", pad_r_y, 330);
    pad_l_up = 1'b0; pad_r_dn = 1'b0;
    pulse_start();
    chk("start_ignored_play", game_state, 2);
    tick_n(1);
    chk("play1_bx", ball_x, 311);
    chk("play1_by", ball_y, 231);
    tick_n(56);
    chk("play57_by", ball_y, 455);
    chk("play57_evt", evt, 0);
    tick_n(1);
    chk("play58_by", ball_y, 455);
    chk("play58_evt_wall", evt, 4'b0001);
    chk("play58_bx", ball_x, 539);
    tick_n(1);
    chk("play59_by_up", ball_y, 451);
    chk("play59_evt_clr", evt, 0);
    tick_n(7);
    chk("play66_bx", ball_x, 571);
    chk("play66_by", ball_y, 423);
    tick_n(1);
    chk("hit_r_bx", ball_x, 575);
    chk("hit_r_by", ball_y, 419);
    chk("hit_r_evt", evt, 4'b0100);
    tick_n(1);
    chk("after_hit_bx", ball_x, 571);
    tick_n(1);
    chk("after_hit2_bx", ball_x, 567);
    chk("after_hit2_state", game_state, 2);

    // Asynchronous reset mid-play takes effect without a clock edge
    @(negedge gclk) grst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge gclk) grst_n = 1'b1;
    @(negedge gclk);

    // Game 2: left wins nine points; right paddle parked away from the ball
    pulse_start();
    for (int r = 0; r < 9; r++) begin
      pad_r_up = ((r % 2) == 0);
      pad_r_dn = ((r % 2) != 0);
      tick_n(60);
      pad_r_up = 1'b0; pad_r_dn = 1'b0;
      if (r == 0) chk("g2_pr_top", pad_r_y, 0);
      if (r == 1) chk("g2_pr_bot", pad_r_y, 330);
      tick_n(1);
      if (r == 1) begin
        chk("serve2_bx", ball_x, 311);
        chk("serve2_by", ball_y, 223);
      end
      tick_n(75);
      if (r == 0) chk("play76_state", game_state, 2);
      tick_n(1);
      chk("miss_state", game_state, 3);
      chk("miss_sl", score_l, r + 1);
      chk("miss_evt", evt, 4'b1000);
      if (r == 0) chk("miss_bx_hold", ball_x, 611);
      tick_n(1);
      if (r < 8) begin
        chk("reserve_state", game_state, 1);
        if (r == 0) begin
          chk("reserve_bx", ball_x, 307);
          chk("reserve_by", ball_y, 227);
        end
      end else begin
        chk("over_state", game_state, 4);
        chk("over_flag", game_over, 1);
      end
    end
    chk("over_sr", score_r, 0);
    tick_n(2);
    chk("over_hold_bx", ball_x, 611);
    chk("over_hold_sl", score_l, 9);
    pulse_start();
    chk("restart_state", game_state, 1);
    chk("restart_sl", score_l, 0);
    chk("restart_over", game_over, 0);
    chk("restart_bx", ball_x, 307);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
